// File: rtl/data_mem_bridge.sv
// Bridges the core's load/store port onto a byte-enabled ready/ack memory bus.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two transactions.
module data_mem_bridge #(
   parameter int TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [2:0]  cpu_memop,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC0 = 2'd1;
`ifdef MISALIGN_SPLIT_EN
   localparam logic [1:0] ACC1 = 2'd2;
`endif
   localparam logic [1:0] RESP = 2'd3;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

   logic [1:0]    state;
   logic [1:0]    off_q;
   logic [2:0]    memop_q;
   logic          we_q;
   logic [CW-1:0] count;
   logic [CW-1:0] count_inc;
   logic [7:0]    req_be8;
   logic          req_valid;
   logic          req_cross;
   logic          req_reject;
   logic [63:0]   load_pair;
   logic [31:0]   load_result;
   logic          split_next;
`ifdef MISALIGN_SPLIT_EN
   logic [63:0]   req_wd;
   logic [3:0]    be_hi_q;
   logic [31:0]   wd_hi_q;
   logic [31:0]   rdata0_q;
`else
   logic [31:0]   req_wd;
`endif

   function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [1:0] sz);
      logic [7:0] base;
      case (sz)
         2'b00:   base = 8'h01;
         2'b01:   base = 8'h03;
         default: base = 8'h0F;
      endcase
      return base << off;
   endfunction

   function automatic logic [31:0] align_load(input logic [2:0] memop, input logic [1:0] off,
                                              input logic [63:0] pair);
      logic [31:0] sh;
      logic [31:0] r;
      sh = 32'(pair >> {off, 3'b000});
      case (memop)
         3'b000:  r = {{24{sh[7]}}, sh[7:0]};
         3'b001:  r = {{16{sh[15]}}, sh[15:0]};
         3'b100:  r = {24'h0, sh[7:0]};
         3'b101:  r = {16'h0, sh[15:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

   // Stores only accept the signed size codes; the unsigned variants are load-only.
   always_comb begin
      req_valid = 1'b0;
      case (cpu_memop)
         3'b000, 3'b001, 3'b010: req_valid = 1'b1;
         3'b100, 3'b101:         req_valid = !cpu_we;
         default:                req_valid = 1'b0;
      endcase
   end

   assign req_be8   = lane_mask(cpu_addr[1:0], cpu_memop[1:0]);
   assign req_cross = |req_be8[7:4];
   assign count_inc = count + 1'b1;
   assign busy      = (state != IDLE);

`ifdef MISALIGN_SPLIT_EN
   assign req_wd     = {32'h0, cpu_wdata} << {cpu_addr[1:0], 3'b000};
   assign req_reject = !req_valid;
   assign split_next = (state == ACC0) && (be_hi_q != 4'h0);
   assign load_pair  = (state == ACC1) ? {mem_rdata, rdata0_q} : {32'h0, mem_rdata};
`else
   assign req_wd     = cpu_wdata << {cpu_addr[1:0], 3'b000};
   assign req_reject = !req_valid || req_cross;
   assign split_next = 1'b0;
   assign load_pair  = {32'h0, mem_rdata};
`endif

   assign load_result = align_load(memop_q, off_q, load_pair);

   // Bus outputs are registered so they stay stable for as long as mem_req is high.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         off_q     <= '0;
         memop_q   <= '0;
         we_q      <= 1'b0;
         count     <= '0;
         cpu_done  <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
`ifdef MISALIGN_SPLIT_EN
         be_hi_q   <= '0;
         wd_hi_q   <= '0;
         rdata0_q  <= '0;
`endif
      end else begin
         cpu_done <= 1'b0;
         cpu_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  off_q   <= cpu_addr[1:0];
                  memop_q <= cpu_memop;
                  we_q    <= cpu_we;
                  if (req_reject) begin
                     state     <= RESP;
                     cpu_done  <= 1'b1;
                     cpu_err   <= 1'b1;
                     cpu_rdata <= '0;
                  end else begin
                     state     <= ACC0;
                     count     <= '0;
                     mem_req   <= 1'b1;
                     mem_we    <= cpu_we;
                     mem_addr  <= {cpu_addr[31:2], 2'b00};
                     mem_be    <= req_be8[3:0];
                     mem_wdata <= req_wd[31:0];
`ifdef MISALIGN_SPLIT_EN
                     be_hi_q   <= req_be8[7:4];
                     wd_hi_q   <= req_wd[63:32];
`endif
                  end
               end
            end
`ifdef MISALIGN_SPLIT_EN
            ACC0, ACC1: begin
`else
            ACC0: begin
`endif
               if (mem_ack && split_next) begin
`ifdef MISALIGN_SPLIT_EN
                  state     <= ACC1;
                  count     <= '0;
                  rdata0_q  <= mem_rdata;
                  mem_addr  <= mem_addr + 32'd4;
                  mem_be    <= be_hi_q;
                  mem_wdata <= wd_hi_q;
`endif
               end else if (mem_ack) begin
                  state     <= RESP;
                  mem_req   <= 1'b0;
                  cpu_done  <= 1'b1;
                  cpu_rdata <= we_q ? 32'h0 : load_result;
               end else if (count_inc == TIMEOUT_CNT) begin
                  state     <= RESP;
                  mem_req   <= 1'b0;
                  cpu_done  <= 1'b1;
                  cpu_err   <= 1'b1;
                  cpu_rdata <= '0;
               end else begin
                  count <= count_inc;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Data-side bridge that sits directly downstream of the single-cycle core's load/store port (address, write data, MemOp, write enable). It converts each byte, halfword or word request into one or two word-aligned, byte-enabled transactions on a ready/ack memory bus. It merges and sign/zero-extends read data and reports completion or error with a one-cycle pulse. Misaligned accesses that cross a word boundary are split into two bus transactions, and unanswered transactions are aborted by a timeout.

## Interface
- `TIMEOUT`, 16: cycles `mem_req` may stay high without `mem_ack` before the access aborts (≥1).
- `clock` in 1: the only clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; low forces all state and outputs to reset values.
- `cpu_req` in 1: request strobe; sampled only in IDLE.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-aligned.
- `cpu_memop` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 only (stores); any other code is invalid.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_err` out 1: valid with `cpu_done`.
- `cpu_rdata` out 32: load result, valid with `cpu_done`, held until the next `cpu_done`.
- `busy` out 1: high whenever the state is not IDLE.
- `mem_req` out 1: bus request; held until `mem_ack` or timeout.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: word address, bits [1:0] = 00.
- `mem_be` out 4: byte enables, bit i = byte lane i.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_ack` in 1: transaction accepted/completed; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read word.

## Operation
- States: IDLE, ACC0, ACC1, RESP. Reset enters IDLE. Reset values are 0 for every output, `busy`, the timeout counter and `cpu_rdata`.
- IDLE with `cpu_req`=1:
  - Latch `cpu_addr`, `cpu_wdata`, `cpu_memop`, `cpu_we`.
  - Invalid memop: go to RESP with err=1 and no bus activity.
  - Otherwise: go to ACC0.
- Lane math, with off = addr[1:0] and size = 1/2/4 bytes:
  - be8 = ((1<<size)-1) << off, an 8-bit mask.
  - wd64 = wdata << (8*off).
  - ACC0 uses word addr[31:2]<<2, be = be8[3:0], wdata = wd64[31:0].
  - ACC1 uses word address +4 (wraps 0xFFFFFFFC → 0x0), be = be8[7:4], wdata = wd64[63:32].
- ACC0 on `mem_ack`:
  - Capture rdata0.
  - If be8[7:4] ≠ 0 (crossing), go to ACC1; otherwise go to RESP.
- ACC1 on `mem_ack`: capture rdata1, then go to RESP.
- Load result: r = ({rdata1, rdata0} >> 8*off)[size*8-1:0], sign-extended for B/H and zero-extended for BU/HU.
- RESP:
  - Pulse `cpu_done`, drive `cpu_err`, update `cpu_rdata`. Loads take the result; stores and errors leave `cpu_rdata` at 0.
  - Return to IDLE.
- Timeout:
  - The counter clears on entry to ACC0/ACC1 and increments each cycle `mem_req`=1 without ack.
  - When it reaches TIMEOUT: drop `mem_req`, go to RESP with err=1 and rdata=0.
  - A second half is never issued after a first-half timeout.
- Write side effects: a store already acked in ACC0 is not rolled back if ACC1 errs.
- `cpu_req` outside IDLE is ignored. The requester must wait for `cpu_done` before issuing again.

## Timing
- `mem_req`/`mem_we`/`mem_addr`/`mem_be`/`mem_wdata` are registered and stable for the whole time `mem_req` is high.
- `mem_req` falls in the cycle after ack.
- Zero-wait memory, single access: `cpu_req` high in cycle 0 → `mem_req` high in cycle 1 with ack in cycle 1 → `cpu_done` in cycle 2. Each wait state adds 1 cycle.
- Split access: `cpu_done` in cycle 3 minimum. ACC1 `mem_req` is high in cycle 2.
- Invalid memop: `cpu_done` in cycle 1, with no `mem_req`.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, then `cpu_done` follows in the next cycle.
- Reset asserted mid-access: `mem_req` and `busy` drop immediately (asynchronously); no `cpu_done` is produced.

## Configuration
- `MISALIGN_SPLIT_EN` defined: crossing accesses are split as described, and ACC1 exists.
- `MISALIGN_SPLIT_EN` undefined: any access with be8[7:4] ≠ 0 goes IDLE → RESP with err=1 and no bus activity. ACC1 logic is removed. Non-crossing misaligned accesses (e.g. LB at off 3, LH at off 2) still complete normally.

## Test plan
- LW at 0x100, memory word 0xDEADBEEF, zero-wait → one transaction (addr 0x100, be 1111), `cpu_done` in cycle 2, rdata 0xDEADBEEF, err 0.
- LB at 0x103 and LBU at 0x103, word 0x80112233 → rdata 0xFFFFFF80 and 0x00000080 respectively.
- SH 0xABCD at 0x203, with split enabled → two transactions:
  - addr 0x200, be 1000, wdata[31:24]=0xCD;
  - then addr 0x204, be 0001, wdata[7:0]=0xAB;
  - `cpu_done` in cycle 3.
- Same SH with `MISALIGN_SPLIT_EN` undefined → no `mem_req`, `cpu_done` in cycle 1, err 1.
- LW with `mem_ack` held low, TIMEOUT=4 → `mem_req` high 4 cycles, then `cpu_done` with err 1 and rdata 0; invalid memop 011 → err 1 in cycle 1.
- Reset driven low while in ACC0 with wait states → `mem_req`=0 and `busy`=0 immediately. After release, an LW to 0x0 completes normally.
